// File: rtl/instr_fetch.sv
// instr_fetch: single-word Avalon-MM instruction fetch with valid/ready handoff to decode,
// PC stall, flush-on-redirect, halt address detection and sticky misalignment fault.
module instr_fetch #(
    parameter bit          BYTE_SWAP = 1'b1,
    parameter logic [31:0] HALT_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        active,
    input  logic        flush,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic [3:0]  avm_byteenable,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        stall,
    output logic        halted,
    output logic        fault
);
    typedef enum logic [1:0] {IDLE, REQ, RESP, HOLD} state_t;
    state_t state;
    logic   drop;
    logic [31:0] rd_word;
    assign rd_word = BYTE_SWAP ? {avm_readdata[7:0], avm_readdata[15:8], avm_readdata[23:16], avm_readdata[31:24]}
                               : avm_readdata;
    assign stall = (halted || fault) ? 1'b0 : !(state == HOLD && instr_ready && !flush);
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            drop           <= 1'b0;
            avm_address    <= '0;
            avm_read       <= 1'b0;
            avm_byteenable <= '0;
            instr          <= '0;
            instr_pc       <= '0;
            instr_valid    <= 1'b0;
            halted         <= 1'b0;
            fault          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fault || halted || !active) begin
                        state <= IDLE;
                    end else if (pc == HALT_ADDR) begin
                        halted <= 1'b1;
                    end else if (pc[1:0] != 2'b00) begin
                        fault <= 1'b1;
                    end else begin
                        avm_address    <= {pc[31:2], 2'b00};
                        avm_byteenable <= 4'hF;
                        avm_read       <= 1'b1;
                        instr_pc       <= pc;
                        state          <= REQ;
                    end
                end
                REQ: begin
                    // a redirect cannot withdraw the read; remember to discard its data
                    if (flush) drop <= 1'b1;
                    if (!avm_waitrequest) begin
                        avm_read <= 1'b0;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    if (!drop && !flush) begin
                        instr       <= rd_word;
                        instr_valid <= 1'b1;
                        state       <= HOLD;
                    end else begin
                        drop  <= 1'b0;
                        state <= IDLE;
                    end
                end
                HOLD: begin
                    if (flush || instr_ready) begin
                        instr_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed-step bench for instr_fetch with hand-computed expectations.
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        rst, active, flush, avm_waitrequest, instr_ready;
    logic [31:0] pc, avm_readdata;
    logic [31:0] avm_address, instr, instr_pc;
    logic        avm_read, instr_valid, stall, halted, fault;
    logic [3:0]  avm_byteenable;
    int          n_cmp = 0;
    int          n_err = 0;

    instr_fetch dut (
        .clk(clk), .rst(rst), .pc(pc), .active(active), .flush(flush),
        .avm_address(avm_address), .avm_read(avm_read), .avm_byteenable(avm_byteenable),
        .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .stall(stall), .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; active = 1'b0; flush = 1'b0; avm_waitrequest = 1'b0; instr_ready = 1'b1;
        pc = 32'hBFC0_0000; avm_readdata = 32'h7856_3412;
        step(); step();
        check("rst_read", {31'b0, avm_read}, 32'd0);
        check("rst_addr", avm_address, 32'd0);
        check("rst_be", {28'b0, avm_byteenable}, 32'd0);
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_flags", {30'b0, halted, fault}, 32'd0);
        // basic fetch: cycle 0 IDLE
        rst = 1'b0; active = 1'b1;
        #1 check("c0_stall", {31'b0, stall}, 32'd1);
        step();
        check("c1_read", {31'b0, avm_read}, 32'd1);
        check("c1_addr", avm_address, 32'hBFC0_0000);
        check("c1_be", {28'b0, avm_byteenable}, 32'hF);
        check("c1_stall", {31'b0, stall}, 32'd1);
        step();
        check("c2_read", {31'b0, avm_read}, 32'd0);
        check("c2_valid", {31'b0, instr_valid}, 32'd0);
        check("c2_stall", {31'b0, stall}, 32'd1);
        step();
        check("c3_valid", {31'b0, instr_valid}, 32'd1);
        check("c3_instr", instr, 32'h1234_5678);
        check("c3_pc", instr_pc, 32'hBFC0_0000);
        check("c3_stall", {31'b0, stall}, 32'd0);
        step();
        // back in IDLE: new fetch with 3 waitrequest cycles
        check("c4_valid", {31'b0, instr_valid}, 32'd0);
        check("c4_stall", {31'b0, stall}, 32'd1);
        pc = 32'hBFC0_0010; avm_waitrequest = 1'b1; avm_readdata = 32'hEFBE_ADDE;
        for (int i = 0; i < 3; i++) begin
            step();
            check("wr_read", {31'b0, avm_read}, 32'd1);
            check("wr_addr", avm_address, 32'hBFC0_0010);
        end
        step();
        avm_waitrequest = 1'b0;
        check("wr_read4", {31'b0, avm_read}, 32'd1);
        check("wr_addr4", avm_address, 32'hBFC0_0010);
        step();
        check("wr_resp", {31'b0, avm_read}, 32'd0);
        check("wr_resp_valid", {31'b0, instr_valid}, 32'd0);
        instr_ready = 1'b0;
        step();
        // HOLD with decode not ready for 5 cycles
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", {31'b0, instr_valid}, 32'd1);
            check("hold_instr", instr, 32'hDEAD_BEEF);
            check("hold_pc", instr_pc, 32'hBFC0_0010);
            check("hold_stall", {31'b0, stall}, 32'd1);
            step();
        end
        check("hold_still", {31'b0, instr_valid}, 32'd1);
        instr_ready = 1'b1; active = 1'b0;
        #1 check("hand_stall", {31'b0, stall}, 32'd0);
        step();
        check("hand_valid", {31'b0, instr_valid}, 32'd0);
        // flush while REQ is stalled
        active = 1'b1; pc = 32'hBFC0_0020; avm_waitrequest = 1'b1;
        step();
        check("fl_req", {31'b0, avm_read}, 32'd1);
        flush = 1'b1; pc = 32'hBFC0_0040;
        step();
        flush = 1'b0;
        check("fl_held", {31'b0, avm_read}, 32'd1);
        check("fl_addr", avm_address, 32'hBFC0_0020);
        avm_waitrequest = 1'b0;
        step();
        check("fl_resp", {31'b0, avm_read}, 32'd0);
        avm_readdata = 32'h0403_0201;
        step();
        check("fl_discard", {31'b0, instr_valid}, 32'd0);
        step();
        check("fl_new_read", {31'b0, avm_read}, 32'd1);
        check("fl_new_addr", avm_address, 32'hBFC0_0040);
        step();
        check("fl_new_resp_valid", {31'b0, instr_valid}, 32'd0);
        step();
        check("fl_new_valid", {31'b0, instr_valid}, 32'd1);
        check("fl_new_pc", instr_pc, 32'hBFC0_0040);
        check("fl_new_instr", instr, 32'h0102_0304);
        active = 1'b0;
        step();
        // reset during REQ
        active = 1'b1; pc = 32'hBFC0_0080; avm_waitrequest = 1'b1;
        step();
        check("rr_req", {31'b0, avm_read}, 32'd1);
        rst = 1'b1;
        step();
        check("rr_read", {31'b0, avm_read}, 32'd0);
        check("rr_valid", {31'b0, instr_valid}, 32'd0);
        check("rr_addr", avm_address, 32'd0);
        rst = 1'b0; avm_waitrequest = 1'b0;
        step();
        check("rr_resume", {31'b0, avm_read}, 32'd1);
        check("rr_resume_addr", avm_address, 32'hBFC0_0080);
        step(); step();
        check("rr_valid2", {31'b0, instr_valid}, 32'd1);
        check("rr_pc", instr_pc, 32'hBFC0_0080);
        active = 1'b0;
        step();
        // halt address
        active = 1'b1; pc = 32'h0000_0000;
        step();
        check("halt_flag", {31'b0, halted}, 32'd1);
        check("halt_stall", {31'b0, stall}, 32'd0);
        pc = 32'hBFC0_0100;
        for (int i = 0; i < 3; i++) begin
            step();
            check("halt_noread", {31'b0, avm_read}, 32'd0);
            check("halt_sticky", {31'b0, halted}, 32'd1);
        end
        rst = 1'b1;
        step();
        check("halt_clr", {31'b0, halted}, 32'd0);
        // misaligned PC
        rst = 1'b0; pc = 32'hBFC0_0002;
        step();
        check("fault_flag", {31'b0, fault}, 32'd1);
        check("fault_stall", {31'b0, stall}, 32'd0);
        pc = 32'hBFC0_0004;
        for (int i = 0; i < 3; i++) begin
            step();
            check("fault_noread", {31'b0, avm_read}, 32'd0);
            check("fault_novalid", {31'b0, instr_valid}, 32'd0);
            check("fault_sticky", {31'b0, fault}, 32'd1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction-fetch stage directly downstream of the program counter.
- Takes the current PC and the CPU active flag, and issues a single-word read on the Avalon-MM instruction bus, handling waitrequest.
- Registers the returned word and presents it to decode with a valid/ready handshake.
- Drives a stall back to the PC-control mux so the PC holds while a fetch is outstanding, and supports flush on branch/jump redirect.

Parameters:
- BYTE_SWAP, 1: when 1, reverse the byte order of readdata to form the instruction (little-endian bus, big-endian MIPS word).
- HALT_ADDR, 32'h00000000: a PC equal to this value halts fetch.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  reset; synchronous, active-high
- pc  input  32  current PC from the pc block
- active  input  1  CPU active flag from the pc block; 0 blocks new fetches
- flush  input  1  redirect; discard the in-flight or held instruction
- avm_address  output  32  word-aligned bus address
- avm_read  output  1  bus read request
- avm_byteenable  output  4  bus byte enables
- avm_readdata  input  32  bus read data
- avm_waitrequest  input  1  bus stall
- instr  output  32  fetched instruction
- instr_pc  output  32  PC the instruction was fetched from
- instr_valid  output  1  instr/instr_pc valid to decode
- instr_ready  input  1  decode accepts instruction
- stall  output  1  PC must hold this cycle
- halted  output  1  fetch stopped at HALT_ADDR
- fault  output  1  misaligned PC detected (sticky)

Behaviour:
- Reset: all registered outputs 0 (avm_address, avm_read, avm_byteenable, instr, instr_pc, instr_valid, halted, fault); state IDLE; drop flag 0. Reset mid-fetch abandons the bus read immediately.
- States: IDLE, REQ, RESP, HOLD.
- IDLE:
  - fault=1 or active=0: stay.
  - pc==HALT_ADDR: halted<=1, stay.
  - pc[1:0]!=0: fault<=1, no bus read, stay.
  - Otherwise: avm_address<={pc[31:2],2'b00}, avm_byteenable<=4'hF, avm_read<=1, instr_pc<=pc, go to REQ.
- REQ:
  - avm_read held 1 and avm_address held stable until a cycle with avm_waitrequest=0.
  - On that cycle: avm_read<=0, go to RESP.
  - A read is never withdrawn once issued.
- RESP:
  - avm_readdata is valid exactly one cycle after acceptance.
  - drop=0 and flush=0: instr<=(BYTE_SWAP ? {rd[7:0],rd[15:8],rd[23:16],rd[31:24]} : rd), instr_valid<=1, go to HOLD.
  - Otherwise: data discarded, drop<=0, go to IDLE.
- HOLD:
  - instr_valid=1, instr/instr_pc stable.
  - flush=1: instr_valid<=0, go to IDLE; flush wins over ready.
  - Else instr_ready=1: instr_valid<=0, go to IDLE.
- Flush in REQ: set drop, keep the bus request until accepted, then discard the response.
- Flush in IDLE: no effect.
- stall (combinational) = !(state==HOLD && instr_ready && !flush), forced 0 while halted or fault.
- Latency, zero waitrequest: PC sampled in IDLE at cycle 0, read accepted cycle 1, data cycle 2, instr_valid cycle 3. Steady-state throughput is 1 instruction per 4 cycles with instr_ready=1; each waitrequest cycle adds 1.
- halted clears only on rst. fault clears only on rst.
- instr_valid never asserts while fault=1.

Test Plan:
- Reset, then pc=32'hBFC00000, active=1, waitrequest=0, readdata=32'h78563412, ready=1 -> avm_read=1 at address BFC00000 cycle 1; instr=32'h12345678, instr_pc=BFC00000, instr_valid=1 in cycle 3; stall low only in cycle 3.
- Same fetch with waitrequest=1 for 3 cycles -> avm_read/address held stable 4 cycles; instr_valid at cycle 6.
- instr_ready=0 for 5 cycles in HOLD -> instr_valid and instr stable, stall=1 throughout; handoff on first ready=1.
- flush asserted while in REQ (waitrequest=1) -> read still completes, no instr_valid; next fetch uses the new pc=32'hBFC00040.
- pc=32'h00000000 -> halted=1, no avm_read ever. pc=32'hBFC00002 -> fault=1, no avm_read, stall=0.
- rst asserted in REQ -> next cycle avm_read=0, instr_valid=0, state IDLE; normal fetch resumes after rst drops.
